axis_pcie_txs_sf_buffer: RTL and testbench
==========================================

// Module: axis_pcie_txs_sf_buffer
// PURPOSE
//  TX-direction AXIS PCIe store-and-forward buffer between the FIM TX mux and the PCIe HIP TX port.
//  Holds beats until a complete TLP (tlast) is stored, then drives it out with no tvalid bubbles.
//  Oversize packets fall back to cut-through so the buffer never deadlocks.
//  Same t_axis_pcie_txs payload, TLP lane layout and s_if/m_if port style as the RX pipeline registers.
// PARAMETERS
//  DEPTH          64  beat capacity; power of 2, >= 4
//  USE_STORE_FWD  1   1: gate output on complete packet; 0: plain FIFO, output when non-empty
// PORTS
//  s_if_clk     in   1            single clock for the whole block
//  s_if_rst_n   in   1            reset, asynchronous, active-low
//  s_if         in   t_axis_pcie_txs  upstream beat {tvalid,tdata,tlast,tuser}
//  s_if_tready  out  1            upstream ready
//  m_if_clk     out  1            = s_if_clk
//  m_if_rst_n   out  1            = s_if_rst_n
//  m_if         out  t_axis_pcie_txs  downstream beat to HIP
//  m_if_tready  in   1            downstream ready
//  occupancy    out  log2(DEPTH)+1  stored beats
//  pkt_cnt      out  log2(DEPTH)+1  complete packets stored
//  err_long_pkt out  1            sticky: a packet exceeded DEPTH beats
// BEHAVIOUR
//  - Reset (async assert, sync release): pointers, occupancy, pkt_cnt, ct_mode, err_long_pkt = 0;
//    s_if_tready=0, m_if.tvalid=0; partial/stored packets discarded. Memory contents not reset.
//  - Storage: DEPTH x {tlast, tuser[TUSER_W-1:0], tdata[TDATA_W-1:0]}; TDATA_W=AXIS_PCIE_DW*FIM_PCIE_TLP_CH,
//    TUSER_W=AXIS_PCIE_TX_UW*FIM_PCIE_TLP_CH. wr_ptr/rd_ptr log2(DEPTH)+1 bits, MSB = wrap bit.
//  - full = occupancy==DEPTH; empty = occupancy==0. s_if_tready = !full (out of reset).
//  - Write: s_if.tvalid & s_if_tready. Read: m_if.tvalid & m_if_tready. Both in one cycle legal,
//    including when full (read frees slot next cycle only; tready stays 0 that cycle).
//  - occupancy: +1 write only, -1 read only, unchanged both/neither.
//  - pkt_cnt: +1 on write of tlast beat, -1 on read of tlast beat, unchanged if both.
//  - m_if data = head entry (combinational from rd_ptr). m_if.tvalid = !empty &
//    (pkt_cnt!=0 | ct_mode | !USE_STORE_FWD).
//  - Latency: beat written at edge N visible on m_if from edge N (cycle after acceptance); single-beat
//    TLP: 1 cycle s_if accept -> m_if.tvalid. Multi-beat: tvalid rises cycle after tlast accepted.
//  - AXIS rule: m_if.tvalid, once high, holds with stable data until read (pkt_cnt/ct_mode/occupancy
//    only drop on a read).
//  - No-bubble guarantee: in store-and-forward, a started packet has all beats stored -> tvalid
//    continuous to tlast.
//  - ct_mode: set when full & pkt_cnt==0 & USE_STORE_FWD; sets err_long_pkt. Cleared on read of a
//    tlast beat. While set, output as plain FIFO (bubbles permitted, tvalid still legal).
//  - Pointer wrap: increment modulo 2*DEPTH; index = low log2(DEPTH) bits.
// STRUCTURE
//  - ofs_fim_if_pkg: t_axis_pcie_txs, AXIS_PCIE_DW, AXIS_PCIE_TX_UW, FIM_PCIE_TLP_CH (existing).
//  - Sub-module pcie_txs_sf_ram: simple dual-port RAM, 1 write port, async read; DEPTH x entry width.
//  - Top holds pointers, counters, ct_mode FSM (IDLE_SF <-> CUT_THRU), status outputs.
// TESTING
//  - Reset: hold rst_n=0 -> s_if_tready=0, m_if.tvalid=0, occupancy=0; release -> tready=1 next edge.
//  - 4-beat TLP, m_if_tready=1: no m_if.tvalid until beat 4 accepted; then 4 contiguous beats,
//    data/tuser/tlast match, pkt_cnt 1->0.
//  - Fill: DEPTH=64, 16 x 4-beat TLPs, m_if_tready=0 -> occupancy=64, pkt_cnt=16, tready=0;
//    simultaneous write/read at full keeps occupancy 64.
//  - Oversize: 70-beat TLP, DEPTH=64 -> ct_mode at occupancy 64 with pkt_cnt 0, err_long_pkt=1,
//    all 70 beats delivered in order, ct_mode clears on tlast read.
//  - Random backpressure (50% m_if_tready, 50% s_if.tvalid), 1000 TLPs 1-16 beats: scoreboard
//    in-order match, no tvalid drop mid-packet, tvalid never falls without handshake.
//  - Reset mid-packet: assert rst_n=0 with 3 stored beats -> outputs clear immediately
//    (async), no stale beat emitted after release.

Source files
------------

// File: rtl/axis_pcie_txs_sf_buffer_pkg.sv
// Shared types for the TX store-and-forward buffer.
// Holds the AXIS PCIe TX beat layout used on the FIM TX mux -> HIP path:
//   t_axis_pcie_txs {tvalid, tdata, tlast, tuser}
// It also holds the RAM entry width and the cut-through FSM state encoding.
package axis_pcie_txs_sf_buffer_pkg;

  localparam int AXIS_PCIE_DW    = 256;
  localparam int AXIS_PCIE_TX_UW = 8;
  localparam int FIM_PCIE_TLP_CH = 2;

  localparam int TDATA_W = AXIS_PCIE_DW * FIM_PCIE_TLP_CH;
  localparam int TUSER_W = AXIS_PCIE_TX_UW * FIM_PCIE_TLP_CH;
  // RAM entry: {tlast, tuser, tdata}
  localparam int ENTRY_W = 1 + TUSER_W + TDATA_W;

  typedef struct packed {
    logic               tvalid;
    logic [TDATA_W-1:0] tdata;
    logic               tlast;
    logic [TUSER_W-1:0] tuser;
  } t_axis_pcie_txs;

  typedef enum logic [0:0] {
    IDLE_SF  = 1'b0,
    CUT_THRU = 1'b1
  } t_sf_state;

  function automatic logic [ENTRY_W-1:0] sf_pack(input t_axis_pcie_txs b);
    return {b.tlast, b.tuser, b.tdata};
  endfunction

endpackage

// File: rtl/axis_pcie_txs_sf_buffer_ram.sv
// Simple dual-port storage for the TX store-and-forward buffer.
// It has one synchronous write port and one asynchronous read port, so the head entry is
// visible in the same cycle that rd_ptr moves. Contents are not reset.
// Ports:
//   clk_i                      write clock
//   we_i, waddr_i, wdata_i     write port
//   raddr_i, rdata_o           combinational read port
module pcie_txs_sf_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axis_pcie_txs_sf_buffer.sv
// TX AXIS PCIe store-and-forward buffer that sits between the FIM TX mux and the HIP TX port.
// Beats are held until a whole TLP (tlast) is stored. The TLP is then sent with no tvalid gaps.
// A packet longer than DEPTH beats fills the buffer with no complete packet stored. In that case
// the block switches to cut-through mode so it cannot deadlock, and it flags err_long_pkt.
// Ports:
//   s_if_clk, s_if_rst_n     clock, async active-low reset
//   s_if, s_if_tready        upstream beat / ready
//   m_if_clk, m_if_rst_n     pass-through of clock and reset
//   m_if, m_if_tready        downstream beat to HIP / ready
//   occupancy, pkt_cnt       stored beats / complete packets stored
//   err_long_pkt             sticky oversize-packet flag
module axis_pcie_txs_sf_buffer
  import axis_pcie_txs_sf_buffer_pkg::*;
#(
  parameter int DEPTH         = 64,
  parameter bit USE_STORE_FWD = 1'b1
) (
  input  logic                   s_if_clk,
  input  logic                   s_if_rst_n,
  input  t_axis_pcie_txs         s_if,
  output logic                   s_if_tready,
  output logic                   m_if_clk,
  output logic                   m_if_rst_n,
  output t_axis_pcie_txs         m_if,
  input  logic                   m_if_tready,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [$clog2(DEPTH):0] pkt_cnt,
  output logic                   err_long_pkt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] occ_q, occ_d;
  logic [PW-1:0] pkt_q, pkt_d;
  logic          rdy_q;
  logic          err_q, err_d;
  t_sf_state     state_q, state_d;

  logic               full, empty, wr_en, rd_en, ct_mode, ct_enter;
  logic [ENTRY_W-1:0] rd_entry;
  logic               rd_last;

  assign m_if_clk   = s_if_clk;
  assign m_if_rst_n = s_if_rst_n;

  assign full  = (occ_q == PW'(DEPTH));
  assign empty = (occ_q == '0);

  // rdy_q is held low by reset and goes high on the first edge after release.
  // This keeps tready low until reset has been released synchronously.
  assign s_if_tready = rdy_q & ~full;

  assign wr_en   = s_if.tvalid & s_if_tready;
  assign rd_en   = m_if.tvalid & m_if_tready;
  assign rd_last = rd_entry[ENTRY_W-1];

  pcie_txs_sf_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .clk_i   (s_if_clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (sf_pack(s_if)),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rd_entry)
  );

  // tvalid can only fall after a read. pkt_cnt, occupancy and ct_mode all drop only on a read,
  // so a beat that is offered stays offered until it is taken.
  always_comb begin
    m_if        = '0;
    m_if.tvalid = ~empty & ((pkt_q != '0) | ct_mode | ~USE_STORE_FWD);
    m_if.tlast  = rd_last;
    m_if.tuser  = rd_entry[TDATA_W +: TUSER_W];
    m_if.tdata  = rd_entry[TDATA_W-1:0];
  end

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + PW'(1) : rd_ptr_q;

    occ_d = occ_q;
    if (wr_en & ~rd_en)      occ_d = occ_q + PW'(1);
    else if (rd_en & ~wr_en) occ_d = occ_q - PW'(1);

    pkt_d = pkt_q;
    if ((wr_en & s_if.tlast) & ~(rd_en & rd_last))      pkt_d = pkt_q + PW'(1);
    else if ((rd_en & rd_last) & ~(wr_en & s_if.tlast)) pkt_d = pkt_q - PW'(1);

    err_d = err_q | ct_enter;
  end

  // Cut-through FSM: state register
  always_ff @(posedge s_if_clk or negedge s_if_rst_n) begin
    if (!s_if_rst_n) state_q <= IDLE_SF;
    else             state_q <= state_d;
  end

  // Cut-through FSM: next state. A full buffer with no complete packet can never make progress
  // in store-and-forward mode. Cut-through drains the buffer until the oversize TLP's tlast is read.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE_SF:  if (USE_STORE_FWD && full && (pkt_q == '0)) state_d = CUT_THRU;
      CUT_THRU: if (rd_en && rd_last)                       state_d = IDLE_SF;
      default:  state_d = IDLE_SF;
    endcase
  end

  // Cut-through FSM: outputs
  always_comb begin
    ct_mode  = (state_q == CUT_THRU);
    ct_enter = (state_q == IDLE_SF) && (state_d == CUT_THRU);
  end

  always_ff @(posedge s_if_clk or negedge s_if_rst_n) begin
    if (!s_if_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      pkt_q    <= '0;
      rdy_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      pkt_q    <= pkt_d;
      rdy_q    <= 1'b1;
      err_q    <= err_d;
    end
  end

  assign occupancy    = occ_q;
  assign pkt_cnt      = pkt_q;
  assign err_long_pkt = err_q;

endmodule

// File: tb/tb_axis_pcie_txs_sf_buffer.sv
// Self-checking bench for axis_pcie_txs_sf_buffer (DEPTH=64, store-and-forward).
// A negedge monitor pushes every accepted input beat into a scoreboard queue.
// It pops and compares each beat the DUT delivers, and checks the AXIS hold and no-bubble rules.
module tb_axis_pcie_txs_sf_buffer;
  import axis_pcie_txs_sf_buffer_pkg::*;

  localparam int DEPTH = 64;
  localparam int PW    = $clog2(DEPTH) + 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  t_axis_pcie_txs s_if = '0;
  t_axis_pcie_txs m_if;
  logic           s_if_tready, m_if_clk, m_if_rst_n, err_long_pkt;
  logic           m_if_tready = 1'b0;
  logic [PW-1:0]  occupancy, pkt_cnt;

  int n_cmp = 0;
  int n_err = 0;

  logic [ENTRY_W-1:0] sb [$];
  logic               nb_en = 1'b1;
  logic               done;

  logic               prev_v = 1'b0, prev_r = 1'b0, prev_mid = 1'b0;
  logic [ENTRY_W-1:0] prev_beat = '0;

  axis_pcie_txs_sf_buffer #(.DEPTH(DEPTH), .USE_STORE_FWD(1'b1)) dut (
    .s_if_clk     (clk),
    .s_if_rst_n   (rst_n),
    .s_if         (s_if),
    .s_if_tready  (s_if_tready),
    .m_if_clk     (m_if_clk),
    .m_if_rst_n   (m_if_rst_n),
    .m_if         (m_if),
    .m_if_tready  (m_if_tready),
    .occupancy    (occupancy),
    .pkt_cnt      (pkt_cnt),
    .err_long_pkt (err_long_pkt)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [575:0] obs, input logic [575:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [TDATA_W-1:0] rnd_data();
    logic [TDATA_W-1:0] d;
    for (int i = 0; i < TDATA_W/32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  // Drive one beat and hold it until the handshake. The task returns 1 time unit after the
  // accepting edge.
  task automatic send_beat(input logic [TDATA_W-1:0] d, input logic [TUSER_W-1:0] u, input logic l);
    logic acc;
    int   n;
    s_if.tvalid = 1'b1;
    s_if.tdata  = d;
    s_if.tuser  = u;
    s_if.tlast  = l;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 5000) begin
      @(negedge clk);
      acc = s_if_tready;
      @(posedge clk);
      #1;
      n++;
    end
    chk("src_accept", acc, 1);
    s_if.tvalid = 1'b0;
  endtask

  task automatic send_pkt(input int nb, input bit gap);
    for (int b = 0; b < nb; b++) begin
      if (gap) repeat ($urandom_range(0, 1)) cyc();
      send_beat(rnd_data(), TUSER_W'($urandom()), b == nb - 1);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (occupancy != '0 && n < 5000) begin
      cyc();
      n++;
    end
    chk("drain_occ", occupancy, 0);
  endtask

  // Scoreboard and protocol monitor
  always @(negedge clk) begin
    logic [ENTRY_W-1:0] exp_b;
    if (!rst_n) begin
      prev_v   = 1'b0;
      prev_r   = 1'b0;
      prev_mid = 1'b0;
    end else begin
      if (prev_v && !prev_r) begin
        chk("hold_vld", m_if.tvalid, 1);
        chk("hold_dat", sf_pack(m_if), prev_beat);
      end
      if (nb_en && prev_mid) chk("no_bubble", m_if.tvalid, 1);
      if (s_if.tvalid && s_if_tready) sb.push_back(sf_pack(s_if));
      if (m_if.tvalid && m_if_tready) begin
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          exp_b = sb.pop_front();
          chk("beat", sf_pack(m_if), exp_b);
        end
      end
      prev_v    = m_if.tvalid;
      prev_r    = m_if_tready;
      prev_beat = sf_pack(m_if);
      prev_mid  = m_if.tvalid && m_if_tready && !m_if.tlast;
    end
  end

  initial begin
    int n;
    // reset
    repeat (3) cyc();
    chk("rst_tready", s_if_tready, 0);
    chk("rst_tvalid", m_if.tvalid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_pkt", pkt_cnt, 0);
    chk("rst_err", err_long_pkt, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_tready0", s_if_tready, 0);
    cyc();
    chk("rel_tready1", s_if_tready, 1);

    // 4-beat TLP: gated until tlast, then contiguous
    m_if_tready = 1'b1;
    for (int b = 0; b < 3; b++) send_beat(rnd_data(), TUSER_W'($urandom()), 1'b0);
    chk("sf_gate", m_if.tvalid, 0);
    send_beat(rnd_data(), TUSER_W'($urandom()), 1'b1);
    chk("sf_vld", m_if.tvalid, 1);
    chk("sf_pkt1", pkt_cnt, 1);
    repeat (4) cyc();
    chk("sf_pkt0", pkt_cnt, 0);
    chk("sf_occ0", occupancy, 0);

    // Fill: 16 x 4-beat TLPs with no reads
    m_if_tready = 1'b0;
    for (int p = 0; p < 16; p++) send_pkt(4, 1'b0);
    chk("fill_occ", occupancy, 64);
    chk("fill_pkt", pkt_cnt, 16);
    chk("fill_tready", s_if_tready, 0);
    chk("fill_tvalid", m_if.tvalid, 1);
    s_if.tvalid = 1'b1;
    s_if.tdata  = rnd_data();
    s_if.tuser  = TUSER_W'($urandom());
    s_if.tlast  = 1'b0;
    m_if_tready = 1'b1;
    cyc();  // full: read only
    chk("full_rd_only", occupancy, 63);
    cyc();  // write + read
    chk("simul_wr_rd", occupancy, 63);
    s_if.tdata = rnd_data();
    s_if.tlast = 1'b1;
    cyc();
    chk("simul_wr_rd2", occupancy, 63);
    s_if.tvalid = 1'b0;
    wait_drain();
    chk("fill_pkt0", pkt_cnt, 0);

    // Oversize 70-beat TLP -> cut-through
    m_if_tready = 1'b0;
    nb_en = 1'b0;
    fork
      send_pkt(70, 1'b0);
      begin
        n = 0;
        while (occupancy != PW'(64) && n < 500) begin
          cyc();
          n++;
        end
        chk("ovr_full", occupancy, 64);
        chk("ovr_pkt", pkt_cnt, 0);
        chk("ovr_gate", m_if.tvalid, 0);
        cyc();
        chk("ovr_vld", m_if.tvalid, 1);
        chk("ovr_err", err_long_pkt, 1);
        m_if_tready = 1'b1;
      end
    join
    wait_drain();
    chk("ovr_pkt0", pkt_cnt, 0);
    chk("ovr_err_sticky", err_long_pkt, 1);
    nb_en = 1'b1;
    // cut-through must have cleared: gating is back
    for (int b = 0; b < 3; b++) send_beat(rnd_data(), TUSER_W'($urandom()), 1'b0);
    chk("ct_clr_gate", m_if.tvalid, 0);
    send_beat(rnd_data(), TUSER_W'($urandom()), 1'b1);
    chk("ct_clr_vld", m_if.tvalid, 1);
    wait_drain();

    // Random traffic with backpressure
    done = 1'b0;
    fork
      begin
        for (int p = 0; p < 1000; p++) send_pkt($urandom_range(1, 16), 1'b1);
        done = 1'b1;
      end
      begin
        while (!done) begin
          m_if_tready = 1'($urandom_range(0, 1));
          cyc();
        end
      end
    join
    m_if_tready = 1'b1;
    wait_drain();
    chk("rnd_sb_empty", sb.size(), 0);

    // Reset with 3 stored beats (1-beat TLP + 2 beats of a partial TLP)
    m_if_tready = 1'b0;
    send_beat(rnd_data(), TUSER_W'($urandom()), 1'b1);
    chk("one_beat_lat", m_if.tvalid, 1);
    send_beat(rnd_data(), TUSER_W'($urandom()), 1'b0);
    send_beat(rnd_data(), TUSER_W'($urandom()), 1'b0);
    chk("mid_occ3", occupancy, 3);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("arst_tvalid", m_if.tvalid, 0);
    chk("arst_tready", s_if_tready, 0);
    chk("arst_occ", occupancy, 0);
    chk("arst_pkt", pkt_cnt, 0);
    chk("arst_err", err_long_pkt, 0);
    repeat (3) cyc();
    rst_n = 1'b1;
    m_if_tready = 1'b1;
    cyc();
    chk("arel_tready", s_if_tready, 1);
    repeat (10) cyc();
    chk("no_stale_occ", occupancy, 0);
    send_pkt(2, 1'b0);
    wait_drain();
    chk("post_rst_sb", sb.size(), 0);

    repeat (2) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
